// File: rtl/gpio_iosim_pkg.sv
// Shared types and gpio bit positions for the GPIO-to-iosim bridge.
package gpio_iosim_pkg;

    typedef enum logic [3:0] {
        CMD_NOP = 4'h0,
        CMD_LDA = 4'h1,
        CMD_LDW = 4'h2,
        CMD_WR  = 4'h3,
        CMD_RD  = 4'h4,
        CMD_POP = 4'h5,
        CMD_CLR = 4'h6
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT,
        ST_ACK
    } state_e;

    localparam int BYTE_LSB   = 0;
    localparam int CMD_LSB    = 8;
    localparam int CH_LSB     = 12;
    localparam int ERR_BIT    = 14;
    localparam int STROBE_BIT = 15;

endpackage

// File: rtl/gpio_iosim_sync.sv
// Flop-chain synchroniser for the command strobe; STAGES=0 passes the level straight through.
module gpio_iosim_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_chain
            logic [STAGES-1:0] r_chain;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_chain <= '0;
                end else begin
                    r_chain[0] <= i_d;
                    for (int i = 1; i < STAGES; i++) begin
                        r_chain[i] <= r_chain[i-1];
                    end
                end
            end

            assign o_q = r_chain[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/gpio_iosim_bridge_mc.sv
// Byte-serial GPIO command bridge to NUM_CH iosim req/gnt back-ends.
// A command is a strobe toggle on gpio_out; completion echoes the strobe level on gpio_in[15].
module gpio_iosim_bridge_mc
    import gpio_iosim_pkg::*;
#(
    parameter int GPIO_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_in,
    output logic              io_req,
    output logic              io_we,
    output logic [2:0]        io_ch,
    output logic [ADDR_W-1:0] io_addr,
    output logic [DATA_W-1:0] io_wdata,
    input  logic              io_gnt,
    input  logic              io_rvalid,
    input  logic [DATA_W-1:0] io_rdata
);

    localparam int               BYTES    = DATA_W / 8;
    localparam int               POP_W    = $clog2(BYTES + 1);
    localparam int               TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [3:0]       NUM_CH_L = 4'(NUM_CH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_e             r_state, w_state_next;
    logic               w_strobe_sync;
    logic               r_last_strobe, r_cap_strobe, r_ack, r_err;
    logic [3:0]         r_cmd;
    logic [7:0]         r_byte, r_rbyte;
    logic [2:0]         r_ch;
    logic [ADDR_W-1:0]  r_addr_sr;
    logic [DATA_W-1:0]  r_wdata_sr, r_rdata_sr;
    logic [POP_W-1:0]   r_pop_cnt;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_io_req, r_io_we;
    logic [2:0]         r_io_ch;
    logic               w_new_cmd, w_ch_ok, w_is_bus, w_done, w_tmo;

    gpio_iosim_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (gpio_out[STROBE_BIT]),
        .o_q   (w_strobe_sync)
    );

    generate
        if (GPIO_W > 16) begin : g_unused
            logic w_unused_bits;
            assign w_unused_bits = ^gpio_out[GPIO_W-1:16];
        end
    endgenerate

    assign w_new_cmd = (w_strobe_sync != r_last_strobe);
    assign w_ch_ok   = ({1'b0, r_ch} < NUM_CH_L);
    assign w_is_bus  = ((r_cmd == CMD_WR) || (r_cmd == CMD_RD)) && w_ch_ok;
    // rvalid may coincide with gnt; outside ISSUE/WAIT both are ignored.
    assign w_done    = ((r_state == ST_ISSUE) && io_gnt && io_rvalid) ||
                       ((r_state == ST_WAIT) && io_rvalid);
    assign w_tmo     = (TIMEOUT_CYC != 0) && (r_tmo_cnt == TMO_LAST) && !w_done &&
                       ((r_state == ST_ISSUE) || (r_state == ST_WAIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_new_cmd) w_state_next = ST_DECODE;
            ST_DECODE: w_state_next = w_is_bus ? ST_ISSUE : ST_ACK;
            ST_ISSUE: begin
                if (w_done || w_tmo) w_state_next = ST_ACK;
                else if (io_gnt)     w_state_next = ST_WAIT;
            end
            ST_WAIT:   if (w_done || w_tmo) w_state_next = ST_ACK;
            ST_ACK:    w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        gpio_in                   = '0;
        gpio_in[BYTE_LSB +: 8]    = r_rbyte;
        gpio_in[ERR_BIT]          = r_err;
        gpio_in[STROBE_BIT]       = r_ack;
        io_req                    = r_io_req;
        io_we                     = r_io_we;
        io_ch                     = r_io_ch;
        io_addr                   = r_addr_sr;
        io_wdata                  = r_wdata_sr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_strobe <= 1'b0;
            r_cap_strobe  <= 1'b0;
            r_ack         <= 1'b0;
            r_err         <= 1'b0;
            r_cmd         <= '0;
            r_byte        <= '0;
            r_ch          <= '0;
            r_rbyte       <= '0;
            r_addr_sr     <= '0;
            r_wdata_sr    <= '0;
            r_rdata_sr    <= '0;
            r_pop_cnt     <= '0;
            r_tmo_cnt     <= '0;
            r_io_req      <= 1'b0;
            r_io_we       <= 1'b0;
            r_io_ch       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_new_cmd) begin
                        r_cmd        <= gpio_out[CMD_LSB +: 4];
                        r_byte       <= gpio_out[BYTE_LSB +: 8];
                        r_ch         <= gpio_out[CH_LSB +: 3];
                        r_cap_strobe <= w_strobe_sync;
                    end
                end
                ST_DECODE: begin
                    // Every accepted command clears the sticky error first.
                    r_err     <= 1'b0;
                    r_tmo_cnt <= '0;
                    case (r_cmd)
                        CMD_NOP: ;
                        CMD_LDA: r_addr_sr  <= (r_addr_sr << 8) | ADDR_W'(r_byte);
                        CMD_LDW: r_wdata_sr <= (r_wdata_sr << 8) | DATA_W'(r_byte);
                        CMD_WR, CMD_RD: begin
                            if (w_ch_ok) begin
                                r_io_req <= 1'b1;
                                r_io_we  <= (r_cmd == CMD_WR);
                                r_io_ch  <= r_ch;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                        CMD_POP: begin
                            if (r_pop_cnt != '0) begin
                                r_rbyte    <= r_rdata_sr[DATA_W-1 -: 8];
                                r_rdata_sr <= r_rdata_sr << 8;
                                r_pop_cnt  <= r_pop_cnt - POP_W'(1);
                            end else begin
                                r_rbyte <= 8'h00;
                                r_err   <= 1'b1;
                            end
                        end
                        CMD_CLR: begin
                            r_addr_sr  <= '0;
                            r_wdata_sr <= '0;
                            r_rdata_sr <= '0;
                            r_pop_cnt  <= '0;
                            r_rbyte    <= 8'h00;
                        end
                        default: r_err <= 1'b1;
                    endcase
                end
                ST_ISSUE, ST_WAIT: begin
                    if ((r_state == ST_ISSUE) && io_gnt) r_io_req <= 1'b0;
                    if (w_done) begin
                        if (!r_io_we) begin
                            r_rdata_sr <= io_rdata;
                            r_pop_cnt  <= POP_W'(BYTES);
                        end
                    end else if (w_tmo) begin
                        r_io_req <= 1'b0;
                        r_err    <= 1'b1;
                        if (!r_io_we) r_rdata_sr <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                ST_ACK: begin
                    r_ack         <= r_cap_strobe;
                    r_last_strobe <= r_cap_strobe;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_iosim_bridge_mc.sv
// Randomised bench for gpio_iosim_bridge_mc against a transaction-level model of the command protocol.
module tb_gpio_iosim_bridge_mc;

    localparam int GPIO_W = 32;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int NUM_CH = 4;
    localparam int SYNC   = 0;
    localparam int TMO    = 16;
    localparam int LIMIT  = 80;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [GPIO_W-1:0] gpio_out;
    logic [GPIO_W-1:0] gpio_in;
    logic              io_req, io_we;
    logic [2:0]        io_ch;
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_wdata;
    logic              io_gnt, io_rvalid;
    logic [DATA_W-1:0] io_rdata;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    // Reference model state
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [7:0]        m_q[$];
    logic              m_err;
    logic [7:0]        m_rbyte;
    logic              m_strobe;

    gpio_iosim_bridge_mc #(
        .GPIO_W(GPIO_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .gpio_out(gpio_out), .gpio_in(gpio_in),
        .io_req(io_req), .io_we(io_we), .io_ch(io_ch), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_addr   = '0;
        m_wdata  = '0;
        m_q      = {};
        m_err    = 1'b0;
        m_rbyte  = 8'h00;
        m_strobe = 1'b0;
    endtask

    // One command: toggle strobe, play the back-end, wait for ack, update model, compare.
    task automatic send(input logic [3:0] cmd, input logic [2:0] ch, input logic [7:0] b,
                        input int g, input int r, input logic [DATA_W-1:0] rd, input bit hang);
        bit bus, seen, acked;
        int n, cyc, req_cnt, exp_lat, exp_req, k;
        bus = ((cmd == 4'h3) || (cmd == 4'h4)) && (int'(ch) < NUM_CH);
        m_strobe = ~m_strobe;
        gpio_out = '0;
        gpio_out[7:0]   = b;
        gpio_out[11:8]  = cmd;
        gpio_out[14:12] = ch;
        gpio_out[15]    = m_strobe;
        seen = 0; acked = 0; cyc = 0; req_cnt = 0; n = 0;
        while (!acked && n < LIMIT) begin
            tick;
            n++;
            io_gnt = 1'b0;
            io_rvalid = 1'b0;
            if (seen) begin
                cyc++;
            end else if (io_req) begin
                seen = 1;
                cyc  = 0;
                chk("io_we", 64'(io_we), 64'(cmd == 4'h3));
                chk("io_ch", 64'(io_ch), 64'(ch));
                chk("io_addr", 64'(io_addr), 64'(m_addr));
                chk("io_wdata", 64'(io_wdata), 64'(m_wdata));
            end
            if (io_req) req_cnt++;
            if (seen && !hang) begin
                io_gnt    = (cyc == g);
                io_rvalid = (cyc == g + r);
                io_rdata  = rd;
            end
            if (gpio_in[15] == m_strobe) acked = 1;
        end
        io_gnt = 1'b0;
        io_rvalid = 1'b0;

        case (cmd)
            4'h0: m_err = 1'b0;
            4'h1: begin m_addr  = (m_addr << 8) | ADDR_W'(b);  m_err = 1'b0; end
            4'h2: begin m_wdata = (m_wdata << 8) | DATA_W'(b); m_err = 1'b0; end
            4'h3, 4'h4: begin
                if (!bus) begin
                    m_err = 1'b1;
                end else if (hang) begin
                    m_err = 1'b1;
                    if (cmd == 4'h4) begin
                        k = m_q.size();
                        m_q = {};
                        repeat (k) m_q.push_back(8'h00);
                    end
                end else begin
                    m_err = 1'b0;
                    if (cmd == 4'h4) begin
                        m_q = {};
                        for (int i = DATA_W/8 - 1; i >= 0; i--) m_q.push_back(rd[i*8 +: 8]);
                    end
                end
            end
            4'h5: begin
                if (m_q.size() > 0) begin m_rbyte = m_q.pop_front(); m_err = 1'b0; end
                else begin m_rbyte = 8'h00; m_err = 1'b1; end
            end
            4'h6: begin
                m_addr = '0; m_wdata = '0; m_q = {}; m_err = 1'b0; m_rbyte = 8'h00;
            end
            default: m_err = 1'b1;
        endcase

        if (!bus)      begin exp_lat = 2 + SYNC;       exp_req = 0;     end
        else if (hang) begin exp_lat = 2 + TMO + SYNC; exp_req = TMO;   end
        else           begin exp_lat = 3 + g + r + SYNC; exp_req = g + 1; end

        chk("ack", 64'(acked), 64'(1));
        chk("latency", 64'(n - 1), 64'(exp_lat));
        chk("req_cycles", 64'(req_cnt), 64'(exp_req));
        chk("rbyte", 64'(gpio_in[7:0]), 64'(m_rbyte));
        chk("err", 64'(gpio_in[14]), 64'(m_err));
        chk("gpio_in_rsvd", 64'({gpio_in[31:16], gpio_in[13:8]}), 64'(0));
        txn++;
        $display("txn %0d cmd=%0h ch=%0d byte=%02h g=%0d r=%0d hang=%0b lat=%0d rbyte=%02h err=%0b",
                 txn, cmd, ch, b, g, r, hang, n - 1, gpio_in[7:0], gpio_in[14]);
    endtask

    task automatic reset_in_wait;
        int n;
        m_strobe = ~m_strobe;
        gpio_out = '0;
        gpio_out[11:8] = 4'h4;
        gpio_out[15]   = m_strobe;
        n = 0;
        while (!io_req && n < LIMIT) begin
            tick;
            n++;
        end
        chk("rst_req_seen", 64'(io_req), 64'(1));
        io_gnt = 1'b1;
        tick;
        io_gnt = 1'b0;
        tick;
        chk("rst_wait_noreq", 64'(io_req), 64'(0));
        rst_n = 1'b0;
        gpio_out = '0;
        tick;
        rst_n = 1'b1;
        model_reset();
        chk("rst_gpio_in", 64'(gpio_in), 64'(0));
        chk("rst_io_req", 64'(io_req), 64'(0));
        io_rdata  = 32'h1234_5678;
        io_rvalid = 1'b1;
        tick;
        io_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("late_rvalid_gpio_in", 64'(gpio_in), 64'(0));
            chk("late_rvalid_req", 64'(io_req), 64'(0));
        end
        txn++;
        $display("txn %0d reset during WAIT, late rvalid ignored gpio_in=%h", txn, gpio_in);
    endtask

    initial begin
        logic [3:0] c;
        logic [2:0] ch;
        int sel;
        rst_n     = 1'b0;
        gpio_out  = '0;
        io_gnt    = 1'b0;
        io_rvalid = 1'b0;
        io_rdata  = '0;
        model_reset();
        repeat (3) tick;
        chk("reset_gpio_in", 64'(gpio_in), 64'(0));
        chk("reset_io_req", 64'(io_req), 64'(0));
        chk("reset_io_we", 64'(io_we), 64'(0));
        chk("reset_io_ch", 64'(io_ch), 64'(0));
        chk("reset_io_addr", 64'(io_addr), 64'(0));
        chk("reset_io_wdata", 64'(io_wdata), 64'(0));
        rst_n = 1'b1;
        tick;

        // Load address/data and write to ch1
        send(4'h1, 3'd0, 8'h12, 0, 0, '0, 0);
        send(4'h1, 3'd0, 8'h34, 0, 0, '0, 0);
        send(4'h1, 3'd0, 8'h56, 0, 0, '0, 0);
        send(4'h1, 3'd0, 8'h78, 0, 0, '0, 0);
        send(4'h2, 3'd0, 8'hDE, 0, 0, '0, 0);
        send(4'h2, 3'd0, 8'hAD, 0, 0, '0, 0);
        send(4'h2, 3'd0, 8'hBE, 0, 0, '0, 0);
        send(4'h2, 3'd0, 8'hEF, 0, 0, '0, 0);
        chk("model_addr", 64'(io_addr), 64'(32'h1234_5678));
        send(4'h3, 3'd1, 8'h00, 3, 2, '0, 0);

        // Read ch0 and pop five bytes
        send(4'h4, 3'd0, 8'h00, 1, 1, 32'hCAFE_F00D, 0);
        repeat (5) send(4'h5, 3'd0, 8'h00, 0, 0, '0, 0);

        // Out-of-range channel, then NOP clears err
        send(4'h3, 3'd5, 8'h00, 0, 0, '0, 0);
        send(4'h0, 3'd0, 8'h00, 0, 0, '0, 0);

        // Timeout on read, then POP
        send(4'h4, 3'd2, 8'h00, 0, 0, '0, 1);
        send(4'h5, 3'd0, 8'h00, 0, 0, '0, 0);

        reset_in_wait();

        // gnt and rvalid in the same cycle as io_req
        send(4'h4, 3'd3, 8'h00, 0, 0, 32'h0BAD_BEEF, 0);
        send(4'h5, 3'd0, 8'h00, 0, 0, '0, 0);

        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 19);
            if (sel < 18) c = 4'(sel % 7);
            else          c = 4'($urandom_range(7, 15));
            if ($urandom_range(0, 7) == 0) ch = 3'($urandom_range(4, 7));
            else                           ch = 3'($urandom_range(0, 3));
            send(c, ch, 8'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
                 DATA_W'($urandom), ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
